// File: rtl/llsc_monitor_if.sv
// ============================================================================
//  Module      : llsc_monitor_if
//  Description : LL/SC monitor bus - MEM-stage requests, external stores and
//                reservation/SC result signals.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface llsc_monitor_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32
);
  logic [NUM_CH-1:0]        ll_valid;
  logic [NUM_CH-1:0]        sc_valid;
  logic [NUM_CH*ADDR_W-1:0] acc_addr;
  logic [NUM_CH-1:0]        flush;
  logic                     st_valid;
  logic [ADDR_W-1:0]        st_addr;
  logic [NUM_CH-1:0]        resv_valid;
  logic [NUM_CH-1:0]        sc_pass;
  logic [NUM_CH-1:0]        sc_fail;
  logic [NUM_CH*16-1:0]     sc_fail_cnt;

  modport master (
    output ll_valid, sc_valid, acc_addr, flush, st_valid, st_addr,
    input  resv_valid, sc_pass, sc_fail, sc_fail_cnt
  );

  modport slave (
    input  ll_valid, sc_valid, acc_addr, flush, st_valid, st_addr,
    output resv_valid, sc_pass, sc_fail, sc_fail_cnt
  );
endinterface

`default_nettype wire

// File: rtl/llsc_monitor.sv
// ============================================================================
//  Module      : llsc_monitor
//  Description : Multi-channel LL/SC reservation monitor with same-cycle SC
//                arbitration, store/flush/timeout invalidation.
//                Optional macro LLSC_STATS_EN enables SC failure counters.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module llsc_monitor #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 32,
  parameter int GRAN_LOG2 = 4,
  parameter int TMO_W     = 10,
  parameter int TMO_MAX   = 1000
) (
  input  wire logic      clk,
  input  wire logic      rst,
  llsc_monitor_if.slave  bus
);

  localparam int               GRAN_W   = ADDR_W - GRAN_LOG2;
  localparam bit               TMO_EN   = (TMO_MAX != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TMO_MAX == 0) ? 0 : TMO_MAX - 1);

  logic [NUM_CH-1:0]             resv_valid_q, resv_valid_d;
  logic [NUM_CH-1:0][GRAN_W-1:0] resv_gran_q, resv_gran_d;
  logic [NUM_CH-1:0][TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;

  logic [NUM_CH-1:0][GRAN_W-1:0] acc_gran;
  logic [GRAN_W-1:0]             st_gran;
  logic [NUM_CH-1:0]             cand;
  logic [NUM_CH-1:0]             sc_pass;
  logic [NUM_CH-1:0]             sc_fail;
  logic [NUM_CH-1:0]             kill;
  logic [NUM_CH-1:0]             tmo_hit;
  logic                          unused_lsb;

  always_comb begin
    acc_gran   = '0;
    unused_lsb = ^bus.st_addr[GRAN_LOG2-1:0];
    for (int i = 0; i < NUM_CH; i++) begin
      acc_gran[i] = bus.acc_addr[i*ADDR_W+GRAN_LOG2 +: GRAN_W];
      unused_lsb  = unused_lsb ^ (^bus.acc_addr[i*ADDR_W +: GRAN_LOG2]);
    end
  end

  assign st_gran = bus.st_addr[ADDR_W-1:GRAN_LOG2];

  // Lowest-index candidate wins among SCs targeting the same granule.
  always_comb begin
    cand    = '0;
    sc_pass = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand[i] = bus.sc_valid[i] & resv_valid_q[i] & ~bus.flush[i] &
                (acc_gran[i] == resv_gran_q[i]);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      sc_pass[i] = cand[i];
      for (int j = 0; j < NUM_CH; j++) begin
        if ((j < i) && cand[j] && (acc_gran[j] == acc_gran[i])) begin
          sc_pass[i] = 1'b0;
        end
      end
    end
  end

  assign sc_fail = bus.sc_valid & ~sc_pass;

  // A passing SC kills other channels' matching reservations, never its own.
  always_comb begin
    kill = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (resv_valid_q[k]) begin
        if (bus.st_valid && (st_gran == resv_gran_q[k])) begin
          kill[k] = 1'b1;
        end
        for (int j = 0; j < NUM_CH; j++) begin
          if ((j != k) && sc_pass[j] && (acc_gran[j] == resv_gran_q[k])) begin
            kill[k] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    tmo_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      tmo_hit[i] = TMO_EN && (tmo_cnt_q[i] == TMO_LAST);
    end
  end

  always_comb begin
    resv_valid_d = resv_valid_q;
    resv_gran_d  = resv_gran_q;
    tmo_cnt_d    = tmo_cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.flush[i]) begin
        resv_valid_d[i] = 1'b0;
        tmo_cnt_d[i]    = '0;
      end else if (bus.ll_valid[i] && !bus.sc_valid[i]) begin
        resv_valid_d[i] = 1'b1;
        resv_gran_d[i]  = acc_gran[i];
        tmo_cnt_d[i]    = '0;
      end else if (bus.sc_valid[i] || kill[i] || (resv_valid_q[i] && tmo_hit[i])) begin
        resv_valid_d[i] = 1'b0;
        tmo_cnt_d[i]    = '0;
      end else if (resv_valid_q[i]) begin
        tmo_cnt_d[i]    = tmo_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resv_valid_q <= '0;
      resv_gran_q  <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      resv_valid_q <= resv_valid_d;
      resv_gran_q  <= resv_gran_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign bus.resv_valid = resv_valid_q;
  assign bus.sc_pass    = sc_pass;
  assign bus.sc_fail    = sc_fail;

`ifdef LLSC_STATS_EN
  logic [NUM_CH-1:0][15:0] fail_cnt_q, fail_cnt_d;

  always_comb begin
    fail_cnt_d = fail_cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sc_fail[i] && (fail_cnt_q[i] != 16'hFFFF)) begin
        fail_cnt_d[i] = fail_cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_cnt_q <= '0;
    end else begin
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign bus.sc_fail_cnt = fail_cnt_q;
`else
  assign bus.sc_fail_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_llsc_monitor.sv
// ============================================================================
//  Module      : tb_llsc_monitor
//  Description : Directed self-checking bench for llsc_monitor.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_llsc_monitor;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  llsc_monitor_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus ();

  llsc_monitor #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .GRAN_LOG2(4), .TMO_W(10), .TMO_MAX(1000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clr();
    bus.ll_valid = '0;
    bus.sc_valid = '0;
    bus.flush    = '0;
    bus.st_valid = 1'b0;
    bus.st_addr  = '0;
  endtask

  task automatic addr(input int ch, input logic [31:0] a);
    bus.acc_addr[ch*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_cnt1;

  initial begin
    n_total      = 0;
    n_pass       = 0;
    rst          = 1'b0;
    bus.acc_addr = '0;
    clr();
`ifdef LLSC_STATS_EN
    exp_cnt1 = 16'd3;
`else
    exp_cnt1 = 16'd0;
`endif
    tick();
    chk("reset_resv", 64'(bus.resv_valid), 64'h0);
    chk("reset_cnt", 64'(bus.sc_fail_cnt), 64'h0);
    rst = 1'b1;
    tick();

    // T1: LL then SC in the same granule at a different offset
    bus.ll_valid = 2'b01; addr(0, 32'h1000);
    tick(); clr();
    chk("t1_resv_set", 64'(bus.resv_valid), 64'h1);
    bus.sc_valid = 2'b01; addr(0, 32'h1008);
    #1;
    chk("t1_pass", 64'(bus.sc_pass), 64'h1);
    chk("t1_fail", 64'(bus.sc_fail), 64'h0);
    tick(); clr();
    chk("t1_resv_clr", 64'(bus.resv_valid), 64'h0);

    // T2: external store in the granule kills, next granule does not
    bus.ll_valid = 2'b01; addr(0, 32'h1000);
    tick(); clr();
    bus.st_valid = 1'b1; bus.st_addr = 32'h100C;
    tick(); clr();
    chk("t2_kill_resv", 64'(bus.resv_valid), 64'h0);
    bus.sc_valid = 2'b01; addr(0, 32'h1000);
    #1;
    chk("t2_kill_fail", 64'(bus.sc_fail), 64'h1);
    chk("t2_kill_pass", 64'(bus.sc_pass), 64'h0);
    tick(); clr();
    bus.ll_valid = 2'b01; addr(0, 32'h1000);
    tick(); clr();
    bus.st_valid = 1'b1; bus.st_addr = 32'h1010;
    tick(); clr();
    chk("t2_miss_resv", 64'(bus.resv_valid), 64'h1);
    bus.sc_valid = 2'b01; addr(0, 32'h1000);
    #1;
    chk("t2_miss_pass", 64'(bus.sc_pass), 64'h1);
    tick(); clr();

    // T3: both channels SC the same granule; ch0 wins (ch1 failure #1)
    bus.ll_valid = 2'b11; addr(0, 32'h2000); addr(1, 32'h2000);
    tick(); clr();
    chk("t3_resv_both", 64'(bus.resv_valid), 64'h3);
    bus.sc_valid = 2'b11;
    #1;
    chk("t3_pass", 64'(bus.sc_pass), 64'h1);
    chk("t3_fail", 64'(bus.sc_fail), 64'h2);
    tick(); clr();
    chk("t3_resv_clr", 64'(bus.resv_valid), 64'h0);

    // Distinct granules: both SCs pass
    bus.ll_valid = 2'b11; addr(0, 32'h2000); addr(1, 32'h2010);
    tick(); clr();
    bus.sc_valid = 2'b11;
    #1;
    chk("t3_distinct_pass", 64'(bus.sc_pass), 64'h3);
    tick(); clr();

    // Passing SC on ch0 kills ch1's reservation (ch1 failure #2)
    bus.ll_valid = 2'b11; addr(0, 32'h2000); addr(1, 32'h2004);
    tick(); clr();
    bus.sc_valid = 2'b01;
    tick(); clr();
    chk("remote_sc_kill", 64'(bus.resv_valid), 64'h0);
    bus.sc_valid = 2'b10;
    #1;
    chk("remote_sc_fail", 64'(bus.sc_fail), 64'h2);
    tick(); clr();

    // T4: timeout boundary on ch1
    bus.ll_valid = 2'b10; addr(1, 32'h3000);
    tick(); clr();
    repeat (999) tick();
    chk("t4_resv_999", 64'(bus.resv_valid), 64'h2);
    bus.sc_valid = 2'b10;
    #1;
    chk("t4_pass_999", 64'(bus.sc_pass), 64'h2);
    tick(); clr();
    bus.ll_valid = 2'b10;
    tick(); clr();
    repeat (999) tick();
    chk("t4_resv_still", 64'(bus.resv_valid), 64'h2);
    tick();
    chk("t4_resv_expired", 64'(bus.resv_valid), 64'h0);
    bus.sc_valid = 2'b10;
    #1;
    chk("t4_fail_1000", 64'(bus.sc_fail), 64'h2);
    tick(); clr();

    // T5: flush beats LL; LL beats same-cycle external store
    bus.ll_valid = 2'b01; bus.flush = 2'b01; addr(0, 32'h4000);
    tick(); clr();
    chk("t5_flush_ll", 64'(bus.resv_valid), 64'h0);
    bus.ll_valid = 2'b01; bus.st_valid = 1'b1; bus.st_addr = 32'h4000;
    tick(); clr();
    chk("t5_ll_beats_st", 64'(bus.resv_valid), 64'h1);
    // Re-arm to a new granule: old granule no longer matches
    bus.ll_valid = 2'b01; addr(0, 32'h5000);
    tick(); clr();
    addr(0, 32'h4000); bus.sc_valid = 2'b01;
    #1;
    chk("rearm_old_fail", 64'(bus.sc_fail), 64'h1);
    tick(); clr();

    // T6: failure counter for ch1
    chk("t6_cnt1", 64'(bus.sc_fail_cnt[31:16]), 64'(exp_cnt1));

    // Asynchronous reset mid-reservation
    bus.ll_valid = 2'b11; addr(0, 32'h6000); addr(1, 32'h7000);
    tick(); clr();
    chk("pre_rst_resv", 64'(bus.resv_valid), 64'h3);
    rst = 1'b0;
    #1;
    chk("async_rst_resv", 64'(bus.resv_valid), 64'h0);
    chk("async_rst_pass", 64'(bus.sc_pass), 64'h0);
    chk("async_rst_fail", 64'(bus.sc_fail), 64'h0);
    chk("async_rst_cnt", 64'(bus.sc_fail_cnt), 64'h0);
    tick();
    rst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
